macc_pipe: RTL

Parametrised pipelined multiply-accumulate unit computing `p = a*b + carryin` or `p = p + a*b + carryin`. It has configurable operand widths, signedness and multiplier pipeline depth. A valid-tagged datapath, a clock enable, and accumulator clear/hold controls are added. It is the successor to the fixed 25x18->48 MAC used in the DSP inference tests, and sits in the same test designs as the synthesis target for multiplier/adder pipeline inference.

---
 rtl/macc_pkg.sv | 32 +++
 rtl/macc_mult_pipe.sv | 90 +++++++++
 rtl/macc_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/macc_pkg.sv
//==============================================================================
// Module      : macc_pkg
// Description : Shared constants and helpers for the pipelined MAC.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package macc_pkg;

    localparam int MAX_MUL_STAGES = 3;
    localparam int c_ext_w        = 128;

    function automatic int macc_latency(input int mul_stages);
        return mul_stages + 2;
    endfunction

    // Extend the low 'w' bits of x to the full container, sign or zero fill.
    function automatic logic [c_ext_w-1:0] ext_to_p(input logic [c_ext_w-1:0] x,
                                                    input int                 w,
                                                    input logic               sgn);
        logic [c_ext_w-1:0] r;
        logic               s;
        s = sgn & x[7'(w - 1)];
        for (int i = 0; i < c_ext_w; i++) begin
            r[i[6:0]] = (i >= w) ? s : x[i[6:0]];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/macc_mult_pipe.sv
//==============================================================================
// Module      : macc_mult_pipe
// Description : Exact multiplier followed by a MUL_STAGES-deep delay line that
//               carries the valid bit and accumulator side-band controls.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module macc_mult_pipe
    import macc_pkg::*;
#(
    parameter int A_WIDTH    = 25,
    parameter int B_WIDTH    = 18,
    parameter int P_WIDTH    = 48,
    parameter int SIGNED     = 0,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic               carryin,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] prod,
    output logic               out_carryin,
    output logic               out_acc_en,
    output logic               out_acc_clr
);

    localparam int c_prod_w = A_WIDTH + B_WIDTH;

    logic                  w_sa;
    logic                  w_sb;
    logic [c_prod_w-1:0]   w_ax;
    logic [c_prod_w-1:0]   w_bx;
    logic [c_prod_w-1:0]   w_prod;
    logic [P_WIDTH-1:0]    w_prod_ext;

    logic [P_WIDTH-1:0]    r_prod [MUL_STAGES];
    logic [MUL_STAGES-1:0] r_vld;
    logic [MUL_STAGES-1:0] r_ci;
    logic [MUL_STAGES-1:0] r_en;
    logic [MUL_STAGES-1:0] r_clr;

    // Low c_prod_w bits of the extended operands' product equal the exact product.
    assign w_sa       = (SIGNED != 0) & a[A_WIDTH-1];
    assign w_sb       = (SIGNED != 0) & b[B_WIDTH-1];
    assign w_ax       = {{B_WIDTH{w_sa}}, a};
    assign w_bx       = {{A_WIDTH{w_sb}}, b};
    assign w_prod     = w_ax * w_bx;
    assign w_prod_ext = P_WIDTH'(ext_to_p(c_ext_w'(w_prod), c_prod_w, SIGNED != 0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_ci  <= '0;
            r_en  <= '0;
            r_clr <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_prod[i] <= '0;
            end
        end else if (ce) begin
            r_prod[0] <= w_prod_ext;
            r_vld[0]  <= in_valid;
            r_ci[0]   <= carryin;
            r_en[0]   <= acc_en;
            r_clr[0]  <= acc_clr;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_vld[i]  <= r_vld[i-1];
                r_ci[i]   <= r_ci[i-1];
                r_en[i]   <= r_en[i-1];
                r_clr[i]  <= r_clr[i-1];
            end
        end
    end

    assign prod        = r_prod[MUL_STAGES-1];
    assign out_valid   = r_vld[MUL_STAGES-1];
    assign out_carryin = r_ci[MUL_STAGES-1];
    assign out_acc_en  = r_en[MUL_STAGES-1];
    assign out_acc_clr = r_clr[MUL_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/macc_pipe.sv
//==============================================================================
// Module      : macc_pipe
// Description : Pipelined multiply-accumulate: input register, multiplier
//               pipe, accumulator with sticky wrap flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module macc_pipe
    import macc_pkg::*;
#(
    parameter int A_WIDTH    = 25,
    parameter int B_WIDTH    = 18,
    parameter int P_WIDTH    = 48,
    parameter int SIGNED     = 0,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic               carryin,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic [P_WIDTH-1:0] p,
    output logic               out_valid,
    output logic               overflow
);

    generate
        if (MUL_STAGES < 1 || MUL_STAGES > MAX_MUL_STAGES ||
            P_WIDTH < A_WIDTH + B_WIDTH || P_WIDTH > c_ext_w ||
            (SIGNED != 0 && SIGNED != 1)) begin : g_param_check
            $error("macc_pipe: illegal parameter combination");
        end
    endgenerate

    logic [A_WIDTH-1:0] r_a;
    logic [B_WIDTH-1:0] r_b;
    logic               r_ci;
    logic               r_en;
    logic               r_clr;
    logic               r_vld;

    logic               w_m_vld;
    logic [P_WIDTH-1:0] w_m_prod;
    logic               w_m_ci;
    logic               w_m_en;
    logic               w_m_clr;

    logic [P_WIDTH-1:0] w_base;
    logic [P_WIDTH-1:0] w_bp;
    logic [P_WIDTH:0]   w_sum;
    logic               w_wrap;

    logic [P_WIDTH-1:0] r_p;
    logic               r_ovf;
    logic               r_outv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_ci  <= 1'b0;
            r_en  <= 1'b0;
            r_clr <= 1'b0;
            r_vld <= 1'b0;
        end else if (ce) begin
            r_a   <= a;
            r_b   <= b;
            r_ci  <= carryin;
            r_en  <= acc_en;
            r_clr <= acc_clr;
            r_vld <= in_valid;
        end
    end

    macc_mult_pipe #(
        .A_WIDTH    (A_WIDTH),
        .B_WIDTH    (B_WIDTH),
        .P_WIDTH    (P_WIDTH),
        .SIGNED     (SIGNED),
        .MUL_STAGES (MUL_STAGES)
    ) u_mult (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_valid    (r_vld),
        .a           (r_a),
        .b           (r_b),
        .carryin     (r_ci),
        .acc_en      (r_en),
        .acc_clr     (r_clr),
        .out_valid   (w_m_vld),
        .prod        (w_m_prod),
        .out_carryin (w_m_ci),
        .out_acc_en  (w_m_en),
        .out_acc_clr (w_m_clr)
    );

    // Wrap is judged on base+prod only in signed mode; carryin is a plain +1.
    assign w_base = (w_m_clr || !w_m_en) ? '0 : r_p;
    assign w_bp   = w_base + w_m_prod;
    assign w_sum  = {1'b0, w_base} + {1'b0, w_m_prod} + {{P_WIDTH{1'b0}}, w_m_ci};
    assign w_wrap = (SIGNED != 0)
                  ? ((w_base[P_WIDTH-1] == w_m_prod[P_WIDTH-1]) &&
                     (w_bp[P_WIDTH-1] != w_base[P_WIDTH-1]))
                  : w_sum[P_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p    <= '0;
            r_ovf  <= 1'b0;
            r_outv <= 1'b0;
        end else if (ce) begin
            r_outv <= w_m_vld;
            if (w_m_vld) begin
                r_p   <= w_sum[P_WIDTH-1:0];
                r_ovf <= w_m_clr ? w_wrap : (r_ovf | w_wrap);
            end
        end
    end

    // Masking with ce reports a result held across a stall once, when ce returns.
    assign p         = r_p;
    assign overflow  = r_ovf;
    assign out_valid = r_outv & ce;

endmodule

`default_nettype wire
